// File: rtl/alu_prf_exec_if.sv
// Issue, flush, write-port and read-port bundle between the core and the ALU/PRF block.
interface alu_prf_exec_if #(
  parameter int unsigned NPREG = 128,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROBW  = 5
);
  localparam int unsigned PW = $clog2(NPREG);

  logic            issued, iss_valid;
  logic [6:0]      iss_opcode;
  logic [2:0]      iss_func3;
  logic [6:0]      iss_func7;
  logic [XLEN-1:0] iss_imm, iss_pc;
  logic [PW-1:0]   iss_pd;
  logic [ROBW-1:0] iss_rob_index;
  logic [XLEN-1:0] ps1_data, ps2_data;
  logic [ROBW-1:0] curr_rob_tag;
  logic            mispredict;
  logic [ROBW-1:0] mispredict_tag;
  logic            write_b_en, write_mem_en;
  logic [XLEN-1:0] data_b_in, data_mem_in;
  logic [PW-1:0]   pd_b_in, pd_mem_in;
  logic            read_en_alu, read_en_b, read_en_mem;
  logic [PW-1:0]   ps1_in_alu, ps2_in_alu, ps1_in_b, ps2_in_b, ps1_in_mem, ps2_in_mem;
  logic [XLEN-1:0] ps1_out_alu, ps2_out_alu, ps1_out_b, ps2_out_b, ps1_out_mem, ps2_out_mem;
  logic            fu_alu_done;
  logic [XLEN-1:0] alu_data;
  logic [PW-1:0]   p_alu;
  logic [ROBW-1:0] alu_rob_tag;

  modport master (
    output issued, iss_valid, iss_opcode, iss_func3, iss_func7, iss_imm, iss_pc, iss_pd,
           iss_rob_index, ps1_data, ps2_data, curr_rob_tag, mispredict, mispredict_tag,
           write_b_en, data_b_in, pd_b_in, write_mem_en, data_mem_in, pd_mem_in,
           read_en_alu, read_en_b, read_en_mem,
           ps1_in_alu, ps2_in_alu, ps1_in_b, ps2_in_b, ps1_in_mem, ps2_in_mem,
    input  ps1_out_alu, ps2_out_alu, ps1_out_b, ps2_out_b, ps1_out_mem, ps2_out_mem,
           fu_alu_done, alu_data, p_alu, alu_rob_tag
  );

  modport slave (
    input  issued, iss_valid, iss_opcode, iss_func3, iss_func7, iss_imm, iss_pc, iss_pd,
           iss_rob_index, ps1_data, ps2_data, curr_rob_tag, mispredict, mispredict_tag,
           write_b_en, data_b_in, pd_b_in, write_mem_en, data_mem_in, pd_mem_in,
           read_en_alu, read_en_b, read_en_mem,
           ps1_in_alu, ps2_in_alu, ps1_in_b, ps2_in_b, ps1_in_mem, ps2_in_mem,
    output ps1_out_alu, ps2_out_alu, ps1_out_b, ps2_out_b, ps1_out_mem, ps2_out_mem,
           fu_alu_done, alu_data, p_alu, alu_rob_tag
  );
endinterface

// File: rtl/alu_prf_exec.sv
// Single-cycle RV32 integer ALU with a 128-entry physical register file:
// three write ports (ALU > branch > mem priority), three combinational read-port pairs.
module alu_prf_exec #(
  parameter int unsigned NPREG = 128,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROBW  = 5
) (
  input logic           clk,
  input logic           reset,
  alu_prf_exec_if.slave bus
);
  localparam int unsigned PW = $clog2(NPREG);

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opc_e;

  logic [XLEN-1:0] prf_q [NPREG];
  logic            done_q, done_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [PW-1:0]   p_q, p_d;
  logic [ROBW-1:0] tag_q, tag_d;

  logic [XLEN-1:0] a, b, alu_res;
  logic [4:0]      shamt;
  logic            op_is_imm;
  logic [ROBW-1:0] age_iss, age_pend, age_curr;
  logic            squash_iss, squash_pend, alu_we;
  logic            unused_func7;

  assign unused_func7 = ^{bus.iss_func7[6], bus.iss_func7[4:0]};

  always_comb begin
    a         = bus.ps1_data;
    op_is_imm = (bus.iss_opcode == OPC_OP_IMM);
    b         = op_is_imm ? bus.iss_imm : bus.ps2_data;
    shamt     = b[4:0];
    alu_res   = '0;
    case (bus.iss_opcode)
      OPC_OP_IMM, OPC_OP: begin
        case (bus.iss_func3)
          3'd0: alu_res = (!op_is_imm && bus.iss_func7[5]) ? a - b : a + b;
          3'd1: alu_res = a << shamt;
          3'd2: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
          3'd3: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
          3'd4: alu_res = a ^ b;
          3'd5: begin
            // Kept as if/else so the arithmetic shift is not forced unsigned by a ternary.
            if (bus.iss_func7[5]) alu_res = $signed(a) >>> shamt;
            else                  alu_res = a >> shamt;
          end
          3'd6:    alu_res = a | b;
          default: alu_res = a & b;
        endcase
      end
      OPC_LUI:   alu_res = bus.iss_imm;
      OPC_AUIPC: alu_res = bus.iss_pc + bus.iss_imm;
      default:   alu_res = '0;
    endcase
  end

  // Ages are measured from the mispredicted branch; anything strictly younger than it
  // and older than the ROB tail is on the wrong path.
  always_comb begin
    age_iss     = bus.iss_rob_index - bus.mispredict_tag;
    age_pend    = tag_q - bus.mispredict_tag;
    age_curr    = bus.curr_rob_tag - bus.mispredict_tag;
    squash_iss  = bus.mispredict && (age_iss != '0) && (age_iss < age_curr);
    squash_pend = bus.mispredict && (age_pend != '0) && (age_pend < age_curr);
    alu_we      = done_q && !squash_pend && (p_q != '0);
  end

  always_comb begin
    done_d = 1'b0;
    data_d = data_q;
    p_d    = p_q;
    tag_d  = tag_q;
    if (bus.issued && bus.iss_valid && !squash_iss) begin
      done_d = 1'b1;
      data_d = alu_res;
      p_d    = bus.iss_pd;
      tag_d  = bus.iss_rob_index;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
      data_q <= '0;
      p_q    <= '0;
      tag_q  <= '0;
    end else begin
      done_q <= done_d;
      data_q <= data_d;
      p_q    <= p_d;
      tag_q  <= tag_d;
    end
  end

  // Later writes in this block win, giving ALU > branch > mem on a shared pd.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NPREG; i++) prf_q[i] <= '0;
    end else begin
      if (bus.write_mem_en && (bus.pd_mem_in != '0)) prf_q[bus.pd_mem_in] <= bus.data_mem_in;
      if (bus.write_b_en && (bus.pd_b_in != '0))     prf_q[bus.pd_b_in]   <= bus.data_b_in;
      if (alu_we)                                    prf_q[p_q]           <= data_q;
    end
  end

  assign bus.ps1_out_alu = bus.read_en_alu ? prf_q[bus.ps1_in_alu] : '0;
  assign bus.ps2_out_alu = bus.read_en_alu ? prf_q[bus.ps2_in_alu] : '0;
  assign bus.ps1_out_b   = bus.read_en_b   ? prf_q[bus.ps1_in_b]   : '0;
  assign bus.ps2_out_b   = bus.read_en_b   ? prf_q[bus.ps2_in_b]   : '0;
  assign bus.ps1_out_mem = bus.read_en_mem ? prf_q[bus.ps1_in_mem] : '0;
  assign bus.ps2_out_mem = bus.read_en_mem ? prf_q[bus.ps2_in_mem] : '0;

  assign bus.fu_alu_done = done_q;
  assign bus.alu_data    = data_q;
  assign bus.p_alu       = p_q;
  assign bus.alu_rob_tag = tag_q;
endmodule

// File: tb/tb_alu_prf_exec.sv
// Self-checking bench for alu_prf_exec: directed scenarios plus randomized traffic
// against an ISA-level reference model of the ALU and register file.
module tb_alu_prf_exec;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_prf_exec_if bus ();
  alu_prf_exec dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  bit [31:0] m_prf [128];
  bit        m_done;
  bit [31:0] m_data;
  bit [6:0]  m_p;
  bit [4:0]  m_tag;

  function automatic int age(input int t, input int m);
    return ((t - m) % 32 + 32) % 32;
  endfunction

  function automatic bit wrong_path(input int t);
    return bus.mispredict && age(t, bus.mispredict_tag) > 0 &&
           age(t, bus.mispredict_tag) < age(bus.curr_rob_tag, bus.mispredict_tag);
  endfunction

  function automatic bit [31:0] ref_alu(input bit [6:0] opc, input bit [2:0] f3, input bit [6:0] f7,
                                        input bit [31:0] x, input bit [31:0] y,
                                        input bit [31:0] imm, input bit [31:0] pc);
    bit [31:0] o;
    int sh;
    if (opc == 7'h37) return imm;
    if (opc == 7'h17) return pc + imm;
    if (opc != 7'h13 && opc != 7'h33) return 0;
    o  = (opc == 7'h13) ? imm : y;
    sh = o % 32;
    case (f3)
      0: return (opc == 7'h33 && f7 == 7'h20) ? x - o : x + o;
      1: return x * (2 ** sh);
      2: return (int'(x) < int'(o)) ? 1 : 0;
      3: return (x < o) ? 1 : 0;
      4: return x ^ o;
      5: return (f7 == 7'h20) ? 32'(int'(x) >>> sh) : x / (2 ** sh);
      6: return x | o;
      default: return x & o;
    endcase
  endfunction

  // Advance one clock: update the model from the inputs presented now, then sample at edge+1.
  task automatic cycle();
    bit        nd;
    bit [31:0] nv;
    if (!reset) begin
      foreach (m_prf[i]) m_prf[i] = 0;
      m_done = 0; m_data = 0; m_p = 0; m_tag = 0;
    end else begin
      nv = ref_alu(bus.iss_opcode, bus.iss_func3, bus.iss_func7, bus.ps1_data, bus.ps2_data,
                   bus.iss_imm, bus.iss_pc);
      nd = bus.issued && bus.iss_valid && !wrong_path(bus.iss_rob_index);
      if (bus.write_mem_en && bus.pd_mem_in != 0) m_prf[bus.pd_mem_in] = bus.data_mem_in;
      if (bus.write_b_en && bus.pd_b_in != 0) m_prf[bus.pd_b_in] = bus.data_b_in;
      if (m_done && !wrong_path(m_tag) && m_p != 0) m_prf[m_p] = m_data;
      m_done = nd;
      if (nd) begin m_data = nv; m_p = bus.iss_pd; m_tag = bus.iss_rob_index; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issued = 0; bus.iss_valid = 0; bus.mispredict = 0;
    bus.write_b_en = 0; bus.write_mem_en = 0;
  endtask

  task automatic issue(input bit [6:0] opc, input bit [2:0] f3, input bit [6:0] f7,
                       input bit [31:0] x, input bit [31:0] y, input bit [31:0] imm,
                       input bit [6:0] pd, input bit [4:0] rob);
    bus.issued = 1; bus.iss_valid = 1; bus.iss_opcode = opc; bus.iss_func3 = f3;
    bus.iss_func7 = f7; bus.ps1_data = x; bus.ps2_data = y; bus.iss_imm = imm;
    bus.iss_pd = pd; bus.iss_rob_index = rob;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) cycle();
    reset = 1;
    bus.read_en_alu = 1; bus.read_en_b = 1; bus.read_en_mem = 1;
    bus.ps1_in_alu = 5; bus.ps2_in_alu = 127; bus.ps1_in_b = 0;
    bus.ps2_in_b = 64; bus.ps1_in_mem = 7; bus.ps2_in_mem = 100;
    #1;
    n_cmp++; if (bus.fu_alu_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", bus.fu_alu_done); end
    n_cmp++; if (bus.alu_data !== 32'd0 || bus.p_alu !== 7'd0 || bus.alu_rob_tag !== 5'd0) begin
      n_err++; $display("FAIL reset_regs got=%h/%0d/%0d exp=0/0/0", bus.alu_data, bus.p_alu, bus.alu_rob_tag); end
    n_cmp++; if ((bus.ps1_out_alu | bus.ps2_out_alu | bus.ps1_out_b | bus.ps2_out_b | bus.ps1_out_mem | bus.ps2_out_mem) !== 32'd0) begin
      n_err++; $display("FAIL reset_reads got nonzero read data exp=0"); end
  endtask

  task automatic test_addi();
    bus.curr_rob_tag = 4;
    issue(7'h13, 0, 0, 10, 0, 5, 5, 3);
    bus.ps1_in_alu = 5;
    cycle();
    n_cmp++; if (bus.fu_alu_done !== 1'b1 || bus.alu_data !== 32'd15 || bus.p_alu !== 7'd5 || bus.alu_rob_tag !== 5'd3) begin
      n_err++; $display("FAIL addi_result got done=%0b data=%0d p=%0d tag=%0d exp 1/15/5/3",
                        bus.fu_alu_done, bus.alu_data, bus.p_alu, bus.alu_rob_tag); end
    n_cmp++; if (bus.ps1_out_alu !== 32'd0) begin n_err++; $display("FAIL addi_no_bypass got=%0d exp=0", bus.ps1_out_alu); end
    idle();
    cycle();
    n_cmp++; if (bus.ps1_out_alu !== 32'd15 || bus.fu_alu_done !== 1'b0) begin
      n_err++; $display("FAIL addi_commit got rd=%0d done=%0b exp 15/0", bus.ps1_out_alu, bus.fu_alu_done); end
    n_cmp++; if (bus.alu_data !== 32'd15) begin n_err++; $display("FAIL addi_hold got=%0d exp=15", bus.alu_data); end
    cycle();
    n_cmp++; if (bus.ps1_out_alu !== 32'd15) begin n_err++; $display("FAIL addi_persist got=%0d exp=15", bus.ps1_out_alu); end
  endtask

  task automatic test_rtype();
    bit [6:0]  opc [6] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h37, 7'h17};
    bit [2:0]  f3  [6] = '{0, 5, 3, 2, 0, 0};
    bit [6:0]  f7  [6] = '{7'h20, 7'h20, 0, 0, 0, 0};
    bit [31:0] x   [6] = '{3, 32'h80000000, 1, 1, 0, 0};
    bit [31:0] y   [6] = '{5, 4, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
    bit [31:0] imm [6] = '{0, 0, 0, 0, 32'h12345000, 32'h00001000};
    bit [31:0] exp [6] = '{32'hFFFFFFFE, 32'hF8000000, 1, 0, 32'h12345000, 32'h00001100};
    bus.iss_pc = 32'h100;
    foreach (opc[i]) begin
      issue(opc[i], f3[i], f7[i], x[i], y[i], imm[i], 7'(20 + i), 5'(i));
      cycle();
      n_cmp++; if (bus.fu_alu_done !== 1'b1 || bus.alu_data !== exp[i]) begin
        n_err++; $display("FAIL rtype_%0d got done=%0b data=%h exp 1/%h", i, bus.fu_alu_done, bus.alu_data, exp[i]); end
    end
    idle();
    cycle();
  endtask

  task automatic test_mispredict();
    bus.read_en_alu = 1;
    bus.mispredict = 1; bus.mispredict_tag = 2; bus.curr_rob_tag = 6;
    issue(7'h13, 0, 0, 99, 0, 1, 9, 4);
    bus.ps1_in_alu = 9;
    cycle();
    n_cmp++; if (bus.fu_alu_done !== 1'b0) begin n_err++; $display("FAIL squash_issue got done=%0b exp=0", bus.fu_alu_done); end
    idle();
    cycle();
    n_cmp++; if (bus.ps1_out_alu !== m_prf[9]) begin n_err++; $display("FAIL squash_prf got=%0d exp=%0d", bus.ps1_out_alu, m_prf[9]); end
    bus.mispredict = 1;
    issue(7'h13, 0, 0, 40, 0, 2, 9, 2);
    cycle();
    n_cmp++; if (bus.fu_alu_done !== 1'b1 || bus.alu_data !== 32'd42) begin
      n_err++; $display("FAIL branch_kept got done=%0b data=%0d exp 1/42", bus.fu_alu_done, bus.alu_data); end
    bus.mispredict_tag = 30; bus.curr_rob_tag = 1;
    issue(7'h13, 0, 0, 7, 0, 1, 10, 0);
    cycle();
    n_cmp++; if (bus.fu_alu_done !== 1'b0) begin n_err++; $display("FAIL squash_wrap got done=%0b exp=0", bus.fu_alu_done); end
    // A completed result whose op turns out wrong-path must not reach the PRF.
    bus.mispredict = 0; bus.curr_rob_tag = 6;
    issue(7'h13, 0, 0, 77, 0, 0, 12, 3);
    bus.ps1_in_alu = 12;
    cycle();
    idle();
    bus.mispredict = 1; bus.mispredict_tag = 1;
    cycle();
    n_cmp++; if (bus.fu_alu_done !== 1'b0 || bus.ps1_out_alu !== m_prf[12]) begin
      n_err++; $display("FAIL squash_pending got done=%0b rd=%0d exp 0/%0d", bus.fu_alu_done, bus.ps1_out_alu, m_prf[12]); end
    idle();
  endtask

  task automatic test_collision();
    bus.curr_rob_tag = 0;
    issue(7'h13, 0, 0, 11, 0, 0, 7, 1);
    cycle();
    idle();
    bus.write_b_en = 1; bus.data_b_in = 22; bus.pd_b_in = 7;
    bus.write_mem_en = 1; bus.data_mem_in = 33; bus.pd_mem_in = 7;
    bus.read_en_mem = 1; bus.ps1_in_mem = 7;
    cycle();
    n_cmp++; if (bus.ps1_out_mem !== 32'd11) begin n_err++; $display("FAIL collision got=%0d exp=11", bus.ps1_out_mem); end
    bus.write_b_en = 1; bus.data_b_in = 55; bus.pd_b_in = 0;
    bus.write_mem_en = 0;
    bus.ps2_in_mem = 0;
    cycle();
    n_cmp++; if (bus.ps2_out_mem !== 32'd0) begin n_err++; $display("FAIL preg0 got=%0d exp=0", bus.ps2_out_mem); end
    idle();
    bus.read_en_b = 0; bus.ps1_in_b = 7;
    #1;
    n_cmp++; if (bus.ps1_out_b !== 32'd0) begin n_err++; $display("FAIL read_disabled got=%0d exp=0", bus.ps1_out_b); end
  endtask

  task automatic test_random();
    bit [6:0] opcs [5] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h63};
    for (int it = 0; it < 300; it++) begin
      bus.issued = ($urandom_range(0, 3) != 0); bus.iss_valid = ($urandom_range(0, 5) != 0);
      bus.iss_opcode = opcs[$urandom_range(0, 4)];
      bus.iss_func3 = 3'($urandom);
      bus.iss_func7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      bus.iss_imm = $urandom; bus.iss_pc = $urandom;
      if ($urandom_range(0, 1) != 0) bus.iss_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      bus.ps1_data = $urandom; bus.ps2_data = $urandom;
      bus.iss_pd = 7'($urandom); bus.iss_rob_index = 5'($urandom);
      bus.curr_rob_tag = 5'($urandom);
      bus.mispredict = ($urandom_range(0, 3) == 0); bus.mispredict_tag = 5'($urandom);
      bus.write_b_en = $urandom_range(0, 1); bus.data_b_in = $urandom; bus.pd_b_in = 7'($urandom);
      bus.write_mem_en = $urandom_range(0, 1); bus.data_mem_in = $urandom; bus.pd_mem_in = 7'($urandom);
      if ($urandom_range(0, 7) == 0) bus.pd_b_in = bus.pd_mem_in;
      bus.read_en_alu = $urandom_range(0, 3) != 0; bus.read_en_b = $urandom_range(0, 3) != 0;
      bus.read_en_mem = $urandom_range(0, 3) != 0;
      bus.ps1_in_alu = 7'($urandom); bus.ps2_in_alu = m_p;
      bus.ps1_in_b = bus.pd_b_in; bus.ps2_in_b = 7'($urandom);
      bus.ps1_in_mem = bus.pd_mem_in; bus.ps2_in_mem = 7'($urandom);
      cycle();
      n_cmp++; if (bus.fu_alu_done !== m_done || (m_done && (bus.alu_data !== m_data || bus.p_alu !== m_p || bus.alu_rob_tag !== m_tag))) begin
        n_err++; $display("FAIL rand_alu it=%0d got done=%0b data=%h p=%0d tag=%0d exp %0b/%h/%0d/%0d",
                          it, bus.fu_alu_done, bus.alu_data, bus.p_alu, bus.alu_rob_tag, m_done, m_data, m_p, m_tag); end
      n_cmp++; if (bus.ps1_out_alu !== (bus.read_en_alu ? m_prf[bus.ps1_in_alu] : 0) ||
                   bus.ps2_out_alu !== (bus.read_en_alu ? m_prf[bus.ps2_in_alu] : 0) ||
                   bus.ps1_out_b   !== (bus.read_en_b   ? m_prf[bus.ps1_in_b]   : 0) ||
                   bus.ps2_out_b   !== (bus.read_en_b   ? m_prf[bus.ps2_in_b]   : 0) ||
                   bus.ps1_out_mem !== (bus.read_en_mem ? m_prf[bus.ps1_in_mem] : 0) ||
                   bus.ps2_out_mem !== (bus.read_en_mem ? m_prf[bus.ps2_in_mem] : 0)) begin
        n_err++; $display("FAIL rand_read it=%0d got %h %h %h %h %h %h", it, bus.ps1_out_alu, bus.ps2_out_alu,
                          bus.ps1_out_b, bus.ps2_out_b, bus.ps1_out_mem, bus.ps2_out_mem); end
    end
    idle();
    cycle();
  endtask

  task automatic test_async_reset();
    bus.curr_rob_tag = 0;
    issue(7'h13, 0, 0, 123, 0, 0, 5, 1);
    cycle();
    idle();
    n_cmp++; if (bus.fu_alu_done !== 1'b1) begin n_err++; $display("FAIL areset_pre got done=%0b exp=1", bus.fu_alu_done); end
    #2 reset = 0;
    #1;
    n_cmp++; if (bus.fu_alu_done !== 1'b0 || bus.alu_data !== 32'd0) begin
      n_err++; $display("FAIL areset_done got done=%0b data=%0d exp 0/0", bus.fu_alu_done, bus.alu_data); end
    cycle();
    reset = 1;
    cycle();
    bus.read_en_alu = 1; bus.ps1_in_alu = 5; bus.ps2_in_alu = 7;
    #1;
    n_cmp++; if (bus.ps1_out_alu !== 32'd0 || bus.ps2_out_alu !== 32'd0) begin
      n_err++; $display("FAIL areset_prf got=%0d/%0d exp 0/0", bus.ps1_out_alu, bus.ps2_out_alu); end
  endtask

  initial begin
    reset = 0;
    idle();
    bus.iss_opcode = 0; bus.iss_func3 = 0; bus.iss_func7 = 0; bus.iss_imm = 0; bus.iss_pc = 0;
    bus.iss_pd = 0; bus.iss_rob_index = 0; bus.ps1_data = 0; bus.ps2_data = 0;
    bus.curr_rob_tag = 0; bus.mispredict_tag = 0;
    bus.data_b_in = 0; bus.pd_b_in = 0; bus.data_mem_in = 0; bus.pd_mem_in = 0;
    bus.read_en_alu = 0; bus.read_en_b = 0; bus.read_en_mem = 0;
    bus.ps1_in_alu = 0; bus.ps2_in_alu = 0; bus.ps1_in_b = 0; bus.ps2_in_b = 0;
    bus.ps1_in_mem = 0; bus.ps2_in_mem = 0;
    test_reset();
    test_addi();
    test_rtype();
    test_mispredict();
    test_collision();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
